shift_iter: RTL and testbench

Multi-cycle, one-bit-per-cycle shift/rotate execution unit for the processor datapath. It computes the same four 16-bit operations as the combinational barrel shifter: logical left, logical right, arithmetic right and rotate right. The operands are accepted through a start/busy/done handshake, so a shift that does not fit the single-cycle path can stall the control FSM. It sits beside the ALU and is driven by the control unit, which holds the instruction in its execute state until `done` is asserted.

---
 rtl/shift_iter.sv | 92 +++++++++
 tb/tb_shift_iter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_iter.sv
// Iterative shift/rotate unit: applies one 1-bit step per cycle to a 16-bit operand.
// Operands are taken through a start/busy/done handshake; all outputs are registered.
module shift_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       shift_type,
    input  logic [3:0]       shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] T_LSL = 2'd0;
    localparam logic [1:0] T_LSR = 2'd1;
    localparam logic [1:0] T_ASR = 2'd2;
    localparam logic [1:0] T_ROR = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       r_type;
    logic [3:0]       r_count;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_data_out;
    logic             r_done;

    logic             w_accept;
    logic [WIDTH-1:0] w_step;

    // Requests are only taken when no shift is in flight; DONE accepts for back-to-back issue.
    assign w_accept = start && (r_state != S_SHIFT);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_step = r_work;
        case (r_type)
            T_LSL:   w_step = {r_work[WIDTH-2:0], 1'b0};
            T_LSR:   w_step = {1'b0, r_work[WIDTH-1:1]};
            T_ASR:   w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            T_ROR:   w_step = {r_work[0], r_work[WIDTH-1:1]};
            default: w_step = r_work;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_type     <= T_LSL;
            r_count    <= 4'd0;
            r_work     <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
        end else begin
            // Outputs trail the DONE state by one edge, giving N+1 cycles of latency.
            r_done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_data_out <= r_work;
            end

            if (w_accept) begin
                r_work  <= data_in;
                r_type  <= shift_type;
                r_count <= shift;
                r_state <= (shift == 4'd0) ? S_DONE : S_SHIFT;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        r_work  <= w_step;
                        r_count <= r_count - 4'd1;
                        if (r_count == 4'd1) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy     = (r_state == S_SHIFT);
    assign done     = r_done;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_shift_iter.sv
// Scoreboard bench for shift_iter: stimulus pushes expected result and due cycle,
// a monitor pops and compares whenever done is presented.
module tb_shift_iter;

    localparam logic [1:0] LSL = 2'd0;
    localparam logic [1:0] LSR = 2'd1;
    localparam logic [1:0] ASR = 2'd2;
    localparam logic [1:0] ROR = 2'd3;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  shift_type;
    logic [3:0]  shift;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [15:0] data_out;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];

    shift_iter #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .shift_type (shift_type),
        .shift      (shift),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [1:0] t, input logic [3:0] n,
                                              input logic [15:0] d);
        logic signed [15:0] s;
        logic [31:0]        dd;
        s  = d;
        dd = {d, d} >> n;
        case (t)
            LSL:     return d << n;
            LSR:     return d >> n;
            ASR:     return s >>> n;
            default: return dd[15:0];
        endcase
    endfunction

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(data_out), 32'hDEAD_0000);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 32'(data_out), 32'(e.data));
                    check("done_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("missing_done", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] t, input logic [3:0] n, input logic [15:0] d,
                         input logic [15:0] exp_val);
        int guard;
        exp_t e;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            check("issue_wait_busy", 32'(busy), 32'd0);
        end else begin
            start      = 1'b1;
            shift_type = t;
            shift      = n;
            data_in    = d;
            e.data     = exp_val;
            e.due      = cyc + 2 + int'(n);
            sb.push_back(e);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int busy_len;
        logic [1:0]  rt;
        logic [3:0]  rn;
        logic [15:0] rd;

        rst_n      = 1'b0;
        start      = 1'b0;
        shift_type = 2'd0;
        shift      = 4'd0;
        data_in    = 16'h0;

        // Reset held: inputs toggle, outputs stay cleared.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start      = ~start;
            shift_type = 2'(i);
            shift      = 4'(3 + i);
            data_in    = 16'hA5A5 ^ 16'(i);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_data_out", 32'(data_out), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_data_out", 32'(data_out), 32'd0);

        // lsl N=4: busy for exactly 4 cycles.
        issue(LSL, 4'd4, 16'h8001, 16'h0010);
        busy_len = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            busy_len++;
            @(negedge clk);
        end
        check("lsl_busy_len", 32'(busy_len), 32'd4);
        drain("drain_lsl");

        issue(ASR, 4'd15, 16'h8000, 16'hFFFF);
        drain("drain_asr");
        issue(ROR, 4'd1, 16'h0001, 16'h8000);
        drain("drain_ror");

        // N=0 for every type returns the operand one cycle after start.
        issue(LSL, 4'd0, 16'h1234, 16'h1234);
        issue(LSR, 4'd0, 16'h1234, 16'h1234);
        issue(ASR, 4'd0, 16'h1234, 16'h1234);
        issue(ROR, 4'd0, 16'h1234, 16'h1234);
        drain("drain_zero");

        // start while busy is ignored.
        issue(LSL, 4'd6, 16'h1234, 16'h8D00);
        check("busy_during_op", 32'(busy), 32'd1);
        start      = 1'b1;
        shift_type = ROR;
        shift      = 4'd1;
        data_in    = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        drain("drain_ignored");

        // Back-to-back issue in the DONE cycle.
        issue(LSR, 4'd4, 16'h00F0, 16'h000F);
        issue(LSL, 4'd4, 16'h00F0, 16'h0F00);
        drain("drain_b2b");

        // Further directed boundary vectors.
        issue(ASR, 4'd4,  16'h7FF0, 16'h07FF);
        issue(ROR, 4'd4,  16'hABCD, 16'hDABC);
        issue(LSR, 4'd15, 16'h8000, 16'h0001);
        issue(LSL, 4'd15, 16'hFFFF, 16'h8000);
        issue(ROR, 4'd15, 16'h8001, 16'h0003);
        issue(ASR, 4'd8,  16'hABCD, 16'hFFAB);
        drain("drain_directed");

        // Random sweep against the reference model.
        for (int i = 0; i < 1000; i++) begin
            rt = 2'($urandom_range(0, 3));
            rn = 4'($urandom_range(0, 15));
            rd = 16'($urandom);
            issue(rt, rn, rd, ref_shift(rt, rn, rd));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain("drain_random");

        // Reset in cycle 3 of a 10-cycle ror.
        issue(ROR, 4'd9, 16'hFEDC, 16'h6E7F);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_hold_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_data_out", 32'(data_out), 32'd0);
        issue(LSR, 4'd8, 16'hABCD, 16'h00AB);
        drain("drain_post_rst");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
